// File: rtl/go_done_launcher_pkg.sv
// Shared types and constants for the go/done job launcher.
package go_done_launcher_pkg;

  localparam int STATE_W       = 3;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

endpackage

// File: rtl/go_done_launcher_if.sv
// Request channel, go/done handshake and status bundle of the launcher.
// Optional stats signals exist only with GO_DONE_LAUNCHER_STATS_EN defined.
interface go_done_launcher_if
  import go_done_launcher_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic               req_valid;
  logic               req_ready;
  logic [CNT_W-1:0]   req_count;
  logic               go;
  logic               done;
  logic               busy;
  logic               batch_done;
  logic               timeout_err;
  logic [CNT_W-1:0]   runs_left;
  logic [STATE_W-1:0] state;
`ifdef GO_DONE_LAUNCHER_STATS_EN
  logic [7:0]         last_latency;
  logic [CNT_W-1:0]   retry_total;
`endif

  // Controller/worker side: drives the request and the done pulse.
  modport master (
    output req_valid, req_count, done,
    input  req_ready, go, busy, batch_done, timeout_err, runs_left, state
`ifdef GO_DONE_LAUNCHER_STATS_EN
    , input last_latency, retry_total
`endif
  );

  // Launcher side.
  modport slave (
    input  req_valid, req_count, done,
    output req_ready, go, busy, batch_done, timeout_err, runs_left, state
`ifdef GO_DONE_LAUNCHER_STATS_EN
    , output last_latency, retry_total
`endif
  );

endinterface

// File: rtl/go_done_launcher_timeout_timer.sv
// Wait-cycle counter: cleared by load, counts while enabled, flags the last allowed cycle.
module timeout_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  assign o_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Holds at the expiry value so it never wraps if the owner keeps enabling it.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/go_done_launcher.sv
// Initiator side of the go/done handshake: runs a batch of jobs with timeout and bounded retry.
// Define GO_DONE_LAUNCHER_STATS_EN to add last_latency / retry_total outputs.
module go_done_launcher
  import go_done_launcher_pkg::*;
#(
  parameter int CNT_W          = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 2
) (
  input logic              clk,
  input logic              rst,
  go_done_launcher_if.slave bus
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e           r_state;
  logic             r_go;
  logic             r_batch_done;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_runs_left;
  logic [RW-1:0]    r_retry_cnt;

  logic w_ready;
  logic w_accept;
  logic w_expire;
  logic w_retry_ok;
  logic w_tmr_load;
  logic w_tmr_en;

  assign w_ready    = (r_state == S_IDLE);
  assign w_accept   = bus.req_valid && w_ready;
  assign w_retry_ok = (r_retry_cnt < RW'(MAX_RETRY));
  assign w_tmr_load = (r_state == S_ISSUE);
  assign w_tmr_en   = (r_state == S_WAIT) && !bus.done;

  timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_tmr_load),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_go          <= 1'b0;
      r_batch_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_runs_left   <= '0;
      r_retry_cnt   <= '0;
    end else begin
      r_go         <= 1'b0;
      r_batch_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_runs_left   <= bus.req_count;
            r_timeout_err <= 1'b0;
            r_retry_cnt   <= '0;
            if (bus.req_count == '0) begin
              r_batch_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_go    <= 1'b1;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          // A done on the expiry cycle still counts as success.
          if (bus.done) begin
            r_retry_cnt <= '0;
            r_runs_left <= r_runs_left - CNT_W'(1);
            if (r_runs_left == CNT_W'(1)) begin
              r_state      <= S_IDLE;
              r_batch_done <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else if (w_expire) begin
            if (w_retry_ok) begin
              r_retry_cnt <= r_retry_cnt + RW'(1);
              r_state     <= S_GAP;
            end else begin
              r_state <= S_FAIL;
            end
          end
        end
        // Spacer so a fresh go never lines up with a late done from the previous attempt.
        S_GAP: begin
          r_state <= S_ISSUE;
          r_go    <= 1'b1;
        end
        S_FAIL: begin
          r_timeout_err <= 1'b1;
          r_runs_left   <= '0;
          r_batch_done  <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.busy        = !w_ready;
  assign bus.go          = r_go;
  assign bus.batch_done  = r_batch_done;
  assign bus.timeout_err = r_timeout_err;
  assign bus.runs_left   = r_runs_left;
  assign bus.state       = r_state;

`ifdef GO_DONE_LAUNCHER_STATS_EN
  logic [7:0]       r_lat;
  logic [7:0]       r_last_latency;
  logic [CNT_W-1:0] r_retry_total;

  // r_lat reads 1 on the first wait cycle, so a done seen there records a latency of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat          <= '0;
      r_last_latency <= '0;
      r_retry_total  <= '0;
    end else begin
      if (w_accept) begin
        r_retry_total <= '0;
      end
      if (r_state == S_ISSUE) begin
        r_lat <= 8'd1;
      end else if (r_state == S_WAIT) begin
        if (bus.done) begin
          r_last_latency <= r_lat;
        end else begin
          if (r_lat != 8'hFF) begin
            r_lat <= r_lat + 8'd1;
          end
          if (w_expire && w_retry_ok) begin
            r_retry_total <= r_retry_total + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.last_latency = r_last_latency;
  assign bus.retry_total  = r_retry_total;
`endif

endmodule

// File: doc/go_done_launcher.md
Name: go_done_launcher

Overview:
- Initiator side of the single-bit go/done job handshake used by the codebase's worker FSMs.
- Accepts a batch request (N runs) from upstream over valid/ready.
- For each run: pulses go, waits for the worker's one-cycle done pulse, and applies a timeout with bounded retry.
- Reports batch completion and sticky errors; sits between a control/CSR block and one worker FSM.

Parameters:
- CNT_W, 8, width of the run counter and request count.
- TIMEOUT_CYCLES, 16, number of S_WAIT cycles without done before a run times out (min 2).
- MAX_RETRY, 2, re-issues allowed per run after a timeout (0 = none).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  upstream batch request valid.
- req_ready  output  1  high only in S_IDLE.
- req_count  input  CNT_W  runs in the batch; sampled on accept.
- go  output  1  one-cycle start pulse to worker.
- done  input  1  worker completion pulse.
- busy  output  1  high whenever state != S_IDLE.
- batch_done  output  1  one-cycle pulse when a batch ends (success or fail).
- timeout_err  output  1  sticky failure flag; cleared on next accept.
- runs_left  output  CNT_W  runs remaining, including the current one.
- state  output  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-run):
  - state=S_IDLE; go=0; batch_done=0; timeout_err=0; runs_left=0; internal wait/retry counters=0.
  - Worker abort is the system's job; the launcher just returns to idle.
- States: S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_GAP=3, S_FAIL=4. Other encodings go to S_IDLE.
- Accept: req_valid & req_ready at cycle T.
  - runs_left <= req_count; timeout_err <= 0.
  - If req_count==0: batch_done=1 at T+1, state stays S_IDLE, go never asserts.
  - Otherwise state=S_ISSUE at T+1.
- S_ISSUE: go=1 for exactly this cycle; wait_cnt <= 0; next state S_WAIT.
- S_WAIT:
  - If done=1: retry_cnt <= 0; runs_left decrements.
    - runs_left==1 → S_IDLE with batch_done=1 on the entry cycle.
    - Else → S_GAP.
  - Else if wait_cnt==TIMEOUT_CYCLES-1:
    - retry_cnt<MAX_RETRY → retry_cnt++, go to S_GAP (re-issue the same run).
    - Else → S_FAIL.
  - Else wait_cnt++.
  - done and timeout expiry in the same cycle: done wins.
- S_GAP: one idle cycle so go never coincides with a trailing done; then S_ISSUE.
- S_FAIL: timeout_err <= 1; runs_left <= 0; batch_done=1 next cycle with state S_IDLE.
- done outside S_WAIT is ignored, with no state change.
- req_valid outside S_IDLE is ignored (ready=0); upstream holds it.
- go, batch_done, timeout_err are registered outputs; req_ready and busy decode the state register.
- Run period against a worker with 4-cycle go→done latency: 6 cycles.

Optional Feature:
- Macro: GO_DONE_LAUNCHER_STATS_EN.
- Defined:
  - Adds output last_latency [7:0]: cycles from go to done of the most recent successful run, saturating at 255.
  - Adds output retry_total [CNT_W-1:0]: retries in the current batch, cleared on accept.
- Undefined: neither port nor logic exists; behaviour otherwise identical.

Decomposition:
- Package go_done_launcher_pkg holds:
  - state enum type (3-bit) and its encodings;
  - default CNT_W;
  - STATE_W=3 constant.
- Sub-module timeout_timer (load/enable/expire counter, parameterised by TIMEOUT_CYCLES) is natural; the FSM instantiates one.

Test Plan:
- Batch of 3 with a model worker (done 4 cycles after go), accept at cycle 0 → go in cycles 1, 7, 13; batch_done in cycle 18; runs_left 3→2→1→0; timeout_err=0.
- req_count=0 accepted at cycle 0 → batch_done=1 in cycle 1, go never high, req_ready stays high.
- Worker never responds, TIMEOUT_CYCLES=16, MAX_RETRY=2 → go pulses 3 times, 18 cycles apart; then S_FAIL, timeout_err=1, batch_done=1; next accept clears timeout_err.
- First go ignored by the worker, second answered → exactly one retry, batch completes with timeout_err=0; with STATS_EN, retry_total=1.
- done injected in S_IDLE and S_GAP, plus done on the exact timeout-expiry cycle → ignored in the first two cases; the last counts as success with no retry.
- rst asserted for 1 cycle while in S_WAIT of run 2 → next cycle state=0, go=0, runs_left=0, busy=0; a new request is accepted normally.
